dmem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port data memory (dmem) between the CPU load/store path (port 0) and a secondary master such as a program loader or debug port (port 1). It registers the winning command, drives dmem's write-enable, address and write-data for one access cycle, and returns read data with a single-cycle acknowledge. It sits between the masters and dmem, and is the only block allowed to drive dmem's inputs.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_arb2.sv | 35 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: FSM state, port id and last_grant reset value.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   typedef logic port_id_t;

   // Port 1 counts as last granted out of reset so port 0 wins the first tie.
   localparam port_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with its last_grant history register.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   output logic [1:0] grant
);

   port_id_t last_grant;

   // One-hot pick: a lone request wins, a tie goes to the port not granted last.
   always_comb begin
      grant = 2'b00;
      if (req0 && req1) begin
         grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
      end else if (req0) begin
         grant = 2'b01;
      end else if (req1) begin
         grant = 2'b10;
      end
   end

   // Remember the winner of every grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= LAST_GRANT_RST;
      end else if (grant != 2'b00) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between port 0 (CPU) and port 1
// (loader/debug). One registered command drives dmem per ACCESS cycle.
// Optional macro DMEM_ARB_BOUNDS_EN flags addresses above the 2**r word range
// as errors and suppresses their write and read data.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int n = 32,
   parameter int r = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [n-1:0] addr0,
   input  logic [n-1:0] addr1,
   input  logic [n-1:0] wdata0,
   input  logic [n-1:0] wdata1,
   output logic         ack0,
   output logic         ack1,
   output logic         err0,
   output logic         err1,
   output logic [n-1:0] rdata0,
   output logic [n-1:0] rdata1,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic [n-1:0] mem_rdata
);

   state_t       state, state_nxt;
   port_id_t     owner;
   logic         cmd_we;
   logic         cmd_err;
   logic         in_access;
   logic         elig0, elig1;
   logic [1:0]   grant;
   logic         grant_any;
   logic         sel_we;
   logic         sel_err;
   logic [n-1:0] sel_addr;
   logic [n-1:0] sel_wdata;

   assign in_access = (state == ACCESS);

   // The owner's request is not eligible during its own ack cycle.
   assign elig0 = req0 && !(in_access && (owner == 1'b0));
   assign elig1 = req1 && !(in_access && (owner == 1'b1));

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .req0  (elig0),
      .req1  (elig1),
      .grant (grant)
   );

   assign grant_any = |grant;

   // Select the winning port's command for registration.
   always_comb begin
      sel_we    = grant[1] ? we1    : we0;
      sel_addr  = grant[1] ? addr1  : addr0;
      sel_wdata = grant[1] ? wdata1 : wdata0;
`ifdef DMEM_ARB_BOUNDS_EN
      sel_err   = |sel_addr[n-1:r+2];
`else
      sel_err   = 1'b0;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and response outputs; any grant keeps the FSM in ACCESS.
   always_comb begin
      state_nxt = state;
      ack0      = 1'b0;
      ack1      = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) state_nxt = ACCESS;
         end
         ACCESS: begin
            if (!grant_any) state_nxt = IDLE;
            ack0   = (owner == 1'b0);
            ack1   = (owner == 1'b1);
            err0   = ack0 && cmd_err;
            err1   = ack1 && cmd_err;
            mem_we = cmd_we && !cmd_err;
            if (ack0 && !cmd_err) rdata0 = mem_rdata;
            if (ack1 && !cmd_err) rdata1 = mem_rdata;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command registers load on every grant and otherwise hold their value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner     <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_any) begin
         owner     <= grant[1];
         cmd_we    <= sel_we;
         cmd_err   <= sel_err;
         mem_addr  <= sel_addr;
         mem_wdata <= sel_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: bench-side dmem, per-port randomized drivers feeding
// a scoreboard checked by a negedge monitor, then directed scenarios.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.n(32), .r(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .err0      (err0),
      .err1      (err1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

`ifdef DMEM_ARB_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   // Bench dmem: combinational read, write on rising edge, plus a preload port.
   logic [31:0] dmem [0:127];
   logic        pl_en = 1'b0;
   logic [6:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   assign mem_rdata = dmem[mem_addr[8:2]];
   always @(posedge clk) begin
      if (pl_en) dmem[pl_idx] <= pl_data;
      else if (mem_we) dmem[mem_addr[8:2]] <= mem_wdata;
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } tx_t;

   tx_t         q0[$];
   tx_t         q1[$];
   logic [31:0] ref_mem [0:127];
   bit          sb_on = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pops the expected transaction for port p and checks the DUT response.
   task automatic sb_check(input int p, input logic a_err, input logic [31:0] a_rdata);
      tx_t  t;
      logic e;
      int   idx;
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
         chk(p == 0 ? "unexpected_ack0" : "unexpected_ack1", 1, 0);
         return;
      end
      t   = (p == 0) ? q0.pop_front() : q1.pop_front();
      idx = int'(t.addr[8:2]);
      e   = BOUNDS && (t.addr[31:9] != '0);
      chk(p == 0 ? "err0" : "err1", a_err, e);
      chk(p == 0 ? "mem_addr0" : "mem_addr1", mem_addr, t.addr);
      chk(p == 0 ? "mem_we0" : "mem_we1", mem_we, t.we && !e);
      if (t.we) begin
         chk(p == 0 ? "mem_wdata0" : "mem_wdata1", mem_wdata, t.wdata);
         if (!e) ref_mem[idx] = t.wdata;
      end else begin
         chk(p == 0 ? "rdata0" : "rdata1", a_rdata, e ? 32'h0 : ref_mem[idx]);
      end
   endtask

   // Monitor: every cycle, one-hot ack, quiet rdata when idle, scoreboard on ack.
   always @(negedge clk) begin
      if (sb_on) begin
         chk("ack_onehot", {31'b0, ack0 && ack1}, 0);
         if (ack0) sb_check(0, err0, rdata0);
         else chk("rdata0_idle", rdata0, 0);
         if (ack1) sb_check(1, err1, rdata1);
         else chk("rdata1_idle", rdata1, 0);
      end
   end

   task automatic drive(input int p, input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0 = rq; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = rq; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // Random master: request, hold until ack, expect ack within two edges.
   task automatic run_port(input int p, input int ntx);
      tx_t t;
      int  waited;
      bit  got;
      for (int i = 0; i < ntx; i++) begin
         repeat (1 + $urandom_range(0, 2)) @(posedge clk);
         #1;
         t.we    = 1'($urandom_range(0, 1));
         t.addr  = {23'h0, 7'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) t.addr[31:9] = 23'($urandom);
         t.wdata = $urandom;
         if (p == 0) q0.push_back(t);
         else q1.push_back(t);
         drive(p, 1'b1, t.we, t.addr, t.wdata);
         waited = 0;
         got    = 1'b0;
         while (!got && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
            if ((p == 0) ? ack0 : ack1) got = 1'b1;
         end
         chk(p == 0 ? "latency0" : "latency1", {31'b0, got && waited <= 2}, 1);
         drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      pl_en = 1'b1; pl_idx = 7'(idx); pl_data = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      for (int i = 0; i < 128; i++) begin
         v = $urandom;
         ref_mem[i] = v;
         preload(i, v);
      end

      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_err0", err0, 0);
      chk("rst_err1", err1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      sb_on = 1'b1;
      fork
         run_port(0, 60);
         run_port(1, 60);
      join
      repeat (3) @(posedge clk);
      #1;
      sb_on = 1'b0;
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      // Tie from reset, then both held: strict alternation starting with port 0.
      do_reset();
      drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h18, 32'h0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("contend_ack0", ack0, (i % 2) == 0);
         chk("contend_ack1", ack1, (i % 2) == 1);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("contend_idle", {30'b0, ack1, ack0}, 0);

      // A single port holding req gets at most every other cycle.
      drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("solo_ack0", ack0, (i % 2) == 0);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      // Single read of a preloaded word.
      preload(5, 32'hDEADBEEF);
      drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
      @(posedge clk);
      #1;
      chk("read_ack0", ack0, 1);
      chk("read_rdata0", rdata0, 32'hDEADBEEF);
      chk("read_ack1", ack1, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("read_ack0_end", ack0, 0);
      chk("read_rdata0_end", rdata0, 0);

      // Port 1 write then read of the same word.
      drive(1, 1'b1, 1'b1, 32'h08, 32'h12345678);
      @(posedge clk);
      #1;
      chk("wr_ack1", ack1, 1);
      chk("wr_mem_we", mem_we, 1);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("wr_mem_we_once", mem_we, 0);
      drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
      @(posedge clk);
      #1;
      chk("rd_ack1", ack1, 1);
      chk("rd_rdata1", rdata1, 32'h12345678);
      chk("rd_mem_we", mem_we, 0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      // Out-of-range write: flagged and dropped with bounds checking, aliased without.
      preload(0, 32'h0BADF00D);
      drive(0, 1'b1, 1'b1, 32'h200, 32'hAABBCCDD);
      @(posedge clk);
      #1;
      chk("oob_ack0", ack0, 1);
      chk("oob_err0", err0, BOUNDS);
      chk("oob_mem_we", mem_we, !BOUNDS);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk("oob_dmem0", dmem[0], BOUNDS ? 32'h0BADF00D : 32'hAABBCCDD);

      // Reset during a port 0 write cycle: nothing commits, outputs clear.
      preload(4, 32'h55AA55AA);
      drive(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
      @(posedge clk);
      #1;
      chk("rstw_ack0", ack0, 1);
      chk("rstw_mem_we", mem_we, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstw_mem_we_drop", mem_we, 0);
      chk("rstw_ack0_drop", ack0, 0);
      chk("rstw_mem_addr", mem_addr, 0);
      chk("rstw_mem_wdata", mem_wdata, 0);
      chk("rstw_rdata0", rdata0, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rstw_dmem4", dmem[4], 32'h55AA55AA);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h18, 32'h0);
      @(posedge clk);
      #1;
      chk("rstw_first_ack0", ack0, 1);
      chk("rstw_first_ack1", ack1, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
